// File: rtl/cff_result_monitor.sv
// Captures a run of result words from cff into a readable buffer while keeping
// a running count and a modular checksum; flags results that arrive after completion.
module cff_result_monitor #(
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned RESULT_ADDR_WIDTH = 11,
    parameter int unsigned EXPECTED_COUNT    = 1024,
    parameter int unsigned CHECK_WIDTH       = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         result_valid,
    input  logic [DATA_WIDTH-1:0]        finalresult,
    input  logic                         rd_en,
    input  logic [RESULT_ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [RESULT_ADDR_WIDTH:0]   result_count,
    output logic [CHECK_WIDTH-1:0]       checksum,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int unsigned CW    = RESULT_ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** RESULT_ADDR_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(EXPECTED_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   wr_c;
    logic   clr_c;
    logic   ovf_set_c;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // State register plus registered status flags decoded from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_CAPTURE);
            done  <= (state_nxt == S_DONE);
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        wr_c      = 1'b0;
        clr_c     = 1'b0;
        ovf_set_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = S_CAPTURE;
                    clr_c     = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (result_valid) begin
                    wr_c = 1'b1;
                    if (result_count == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ovf_set_c = result_valid;
                if (!enable) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Count, checksum (carry discarded) and sticky overflow
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_count <= '0;
            checksum     <= '0;
            overflow     <= 1'b0;
        end else if (clr_c) begin
            result_count <= '0;
            checksum     <= '0;
            overflow     <= 1'b0;
        end else begin
            if (wr_c) begin
                result_count <= result_count + CW'(1);
                checksum     <= checksum + CHECK_WIDTH'(finalresult);
            end
            if (ovf_set_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // Capture buffer; contents intentionally not reset
    always_ff @(posedge clock) begin
        if (wr_c) begin
            mem[result_count[RESULT_ADDR_WIDTH-1:0]] <= finalresult;
        end
    end

    // Registered read port; same-edge write returns the old word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
